// File: rtl/rtl_settings_pkg.sv
// rtl/rtl_settings_pkg.sv - shared bus widths, address mode, sequencer state and mode encodings
package rtl_settings_pkg;

    localparam int    ADDR_W      = 16;
    localparam int    DATA_W      = 32;
    localparam int    DATA_B_W    = DATA_W / 8;
    localparam int    AMM_BURST_W = 8;
    localparam string ADDR_TYPE   = "BYTE";

    // Byte-addressed slaves step by whole words per beat, word-addressed ones by one.
    localparam int ADDR_MUL = (ADDR_TYPE == "BYTE") ? DATA_B_W : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        RD_REQ,
        RD_WAIT,
        DRAIN,
        DONE
    } seq_state_t;

    localparam logic [1:0] MODE_WR    = 2'd0;
    localparam logic [1:0] MODE_RD    = 2'd1;
    localparam logic [1:0] MODE_WR_RD = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    function automatic logic [ADDR_W-1:0] burst_step(input logic [AMM_BURST_W-1:0] bc);
        return ADDR_W'(bc) * ADDR_W'(ADDR_MUL);
    endfunction

    function automatic logic [DATA_W-1:0] beat_pattern(input logic [23:0] burst,
                                                       input logic [AMM_BURST_W-1:0] beat);
        logic [31:0] word;
        word = {burst, 8'(beat)};
        return {(DATA_W/32){word}};
    endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// rtl/test_sequencer_if.sv - burst memory bus between the sequencer and the memory slave
interface test_sequencer_if;
    import rtl_settings_pkg::*;

    logic [ADDR_W-1:0]      address_o;
    logic                   read_o;
    logic                   write_o;
    logic [AMM_BURST_W-1:0] burstcount_o;
    logic [DATA_W-1:0]      writedata_o;
    logic [DATA_B_W-1:0]    byteenable_o;
    logic                   waitrequest_i;
    logic                   readdatavalid_i;

    modport master (
        output address_o, read_o, write_o, burstcount_o, writedata_o, byteenable_o,
        input  waitrequest_i, readdatavalid_i
    );

    modport slave (
        input  address_o, read_o, write_o, burstcount_o, writedata_o, byteenable_o,
        output waitrequest_i, readdatavalid_i
    );
endinterface

// File: rtl/rd_outst_tracker.sv
// rtl/rd_outst_tracker.sv - counts read bursts in flight, retiring one when its last beat returns
module rd_outst_tracker #(
    parameter  int MAX_OUTST = 4,
    parameter  int BURST_W   = 8,
    localparam int CNT_W     = $clog2(MAX_OUTST + 1),
    localparam int PTR_W     = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [BURST_W-1:0] push_len_i,
    input  logic               rdv_i,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o
);

    logic [BURST_W-1:0] len_q [MAX_OUTST];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [BURST_W-1:0] beat_q;
    logic               rdv_ok;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Stray data with nothing in flight is dropped so the count cannot underflow.
    assign rdv_ok = rdv_i && (count_q != '0);
    assign pop    = rdv_ok && (beat_q == len_q[rd_ptr_q] - 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                len_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
        end else begin
            if (push_i) begin
                len_q[wr_ptr_q] <= push_len_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                beat_q   <= '0;
            end else if (rdv_ok) begin
                beat_q <= beat_q + 1'b1;
            end
            case ({push_i, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(MAX_OUTST));

endmodule

// File: rtl/test_sequencer.sv
// rtl/test_sequencer.sv - issues write and/or read burst phases against memory for a throughput test
module test_sequencer
    import rtl_settings_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_start_i,
    input  logic [1:0]             mode_i,
    input  logic [ADDR_W-1:0]      base_addr_i,
    input  logic [31:0]            burst_num_i,
    input  logic [AMM_BURST_W-1:0] burstcount_cfg_i,
    test_sequencer_if.master       bus,
    output logic                   meas_start_o,
    input  logic                   meas_busy_i,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    seq_state_t             state_q;
    logic [1:0]             mode_q;
    logic [ADDR_W-1:0]      base_q;
    logic [31:0]            burst_num_q;
    logic [AMM_BURST_W-1:0] bc_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [31:0]            burst_idx_q;
    logic [AMM_BURST_W-1:0] beat_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   write_q;
    logic                   read_q;
    logic                   meas_start_q;
    logic                   done_q;
    logic                   idle_seen_q;

    logic                   wr_acc;
    logic                   rd_acc;
    logic                   last_beat;
    logic                   last_burst;
    logic [ADDR_W-1:0]      addr_d;
    logic [CNT_W-1:0]       outst;
    logic                   outst_full;

    assign wr_acc     = write_q && !bus.waitrequest_i;
    assign rd_acc     = read_q && !bus.waitrequest_i;
    assign last_beat  = (beat_q == bc_q - 1'b1);
    assign last_burst = (burst_idx_q == burst_num_q - 32'd1);
    assign addr_d     = addr_q + burst_step(bc_q);

    rd_outst_tracker #(
        .MAX_OUTST (MAX_OUTST),
        .BURST_W   (AMM_BURST_W)
    ) u_rd_outst_tracker (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (rd_acc),
        .push_len_i (bc_q),
        .rdv_i      (bus.readdatavalid_i),
        .count_o    (outst),
        .full_o     (outst_full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mode_q       <= MODE_WR;
            base_q       <= '0;
            burst_num_q  <= '0;
            bc_q         <= '0;
            addr_q       <= '0;
            burst_idx_q  <= '0;
            beat_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            meas_start_q <= 1'b0;
            done_q       <= 1'b0;
            idle_seen_q  <= 1'b0;
        end else begin
            meas_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (test_start_i) begin
                        mode_q       <= mode_i;
                        base_q       <= base_addr_i;
                        burst_num_q  <= burst_num_i;
                        bc_q         <= burstcount_cfg_i;
                        addr_q       <= base_addr_i;
                        burst_idx_q  <= '0;
                        beat_q       <= '0;
                        wdata_q      <= beat_pattern(24'd0, '0);
                        idle_seen_q  <= 1'b0;
                        meas_start_q <= 1'b1;
                        if (mode_i == MODE_RSVD || burst_num_i == 32'd0 || burstcount_cfg_i == '0) begin
                            state_q <= DONE;
                        end else if (mode_i == MODE_RD) begin
                            state_q <= RD_REQ;
                        end else begin
                            state_q <= WR_BURST;
                            write_q <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_acc) begin
                        if (!last_beat) begin
                            beat_q  <= beat_q + 1'b1;
                            wdata_q <= beat_pattern(burst_idx_q[23:0], beat_q + 1'b1);
                        end else if (!last_burst) begin
                            // Next burst follows back-to-back without dropping write.
                            burst_idx_q <= burst_idx_q + 32'd1;
                            beat_q      <= '0;
                            addr_q      <= addr_d;
                            wdata_q     <= beat_pattern(burst_idx_q[23:0] + 24'd1, '0);
                        end else begin
                            write_q     <= 1'b0;
                            beat_q      <= '0;
                            burst_idx_q <= '0;
                            if (mode_q == MODE_WR_RD) begin
                                addr_q  <= base_q;
                                state_q <= RD_REQ;
                            end else begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                end
                RD_REQ: begin
                    if (!read_q) begin
                        if (!outst_full) begin
                            read_q <= 1'b1;
                        end
                    end else if (!bus.waitrequest_i) begin
                        read_q <= 1'b0;
                        if (last_burst) begin
                            state_q <= RD_WAIT;
                        end else begin
                            burst_idx_q <= burst_idx_q + 32'd1;
                            addr_q      <= addr_d;
                        end
                    end
                end
                RD_WAIT: begin
                    if (outst == '0) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The measurement block must report idle on two consecutive cycles.
                    if (meas_busy_i) begin
                        idle_seen_q <= 1'b0;
                    end else if (idle_seen_q) begin
                        state_q <= DONE;
                    end else begin
                        idle_seen_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.address_o    = addr_q;
    assign bus.read_o       = read_q;
    assign bus.write_o      = write_q;
    assign bus.burstcount_o = bc_q;
    assign bus.writedata_o  = wdata_q;
    assign bus.byteenable_o = '1;

    assign meas_start_o = meas_start_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter MAX_OUTST, default 4, maximum read bursts in flight; SHALL equal the measurement block's concurrent delay-counter count.
REQ-002 Parameters ADDR_W, DATA_W, DATA_B_W, AMM_BURST_W and ADDR_TYPE ("BYTE"/"WORD") SHALL come from rtl_settings_pkg and are not redeclared locally.
REQ-003 Ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-004 Ports: test_start_i in 1 one-cycle start pulse; mode_i in 2 phase select: 0 write-only, 1 read-only, 2 write-then-read, 3 reserved.
REQ-005 Ports: base_addr_i in ADDR_W first burst address; burst_num_i in 32 bursts per phase; burstcount_cfg_i in AMM_BURST_W beats per burst.
REQ-006 Ports: address_o out ADDR_W; read_o out 1; write_o out 1; burstcount_o out AMM_BURST_W; writedata_o out DATA_W; byteenable_o out DATA_B_W; waitrequest_i in 1; readdatavalid_i in 1.
REQ-007 Ports: meas_start_o out 1 clear pulse to measurement block; meas_busy_i in 1; busy_o out 1; done_o out 1 one-cycle completion pulse.

Function
REQ-008 FSM states SHALL be IDLE, WR_BURST, RD_REQ, RD_WAIT, DRAIN, DONE.
REQ-009 IDLE: test_start_i SHALL latch all configuration inputs and assert meas_start_o for exactly one cycle in the following cycle; test_start_i outside IDLE SHALL be ignored.
REQ-010 Start transitions: mode 0/2 -> WR_BURST; mode 1 -> RD_REQ; mode 3, burst_num_i == 0 or burstcount_cfg_i == 0 -> DONE directly, with no bus activity.
REQ-011 WR_BURST: write_o SHALL stay high until burstcount beats are accepted; a beat is accepted in a cycle with write_o=1 and waitrequest_i=0.
REQ-012 address_o and burstcount_o SHALL hold constant for the whole burst; byteenable_o SHALL be all ones.
REQ-013 writedata_o SHALL be the 32-bit value {burst index[23:0], beat index[7:0]} replicated DATA_W/32 times, and SHALL change only after an accepted beat.
REQ-014 After the last beat of a burst, the address SHALL advance by burstcount ("WORD") or burstcount*DATA_B_W ("BYTE"), wrapping modulo 2^ADDR_W.
REQ-015 After the final write burst, mode 2 SHALL reload the address from the latched base and go to RD_REQ; mode 0 SHALL go to DRAIN.
REQ-016 RD_REQ: read_o SHALL be asserted only while outstanding < MAX_OUTST and bursts remain; once asserted, read_o, address_o and burstcount_o SHALL hold until waitrequest_i=0.
REQ-017 outstanding SHALL increment on an accepted read, and decrement when the last beat (burstcount readdatavalid_i pulses) of the oldest burst returns; both in one cycle leaves it unchanged.
REQ-018 After the final read is accepted -> RD_WAIT; RD_WAIT -> DRAIN when outstanding == 0.
REQ-019 DRAIN -> DONE when meas_busy_i == 0 for two consecutive cycles; DONE SHALL pulse done_o for one cycle, then -> IDLE.
REQ-020 busy_o SHALL be high in every state except IDLE; read_o and write_o SHALL never be high in the same cycle.
REQ-021 readdatavalid_i while outstanding == 0 SHALL be ignored and SHALL NOT underflow the count.
REQ-022 A beat counter of AMM_BURST_W bits and a 32-bit burst counter SHALL be used; burst_num_i = 2^32-1 SHALL complete without overflow.

Reset
REQ-023 Asynchronous reset SHALL force IDLE, outstanding = 0, all counters = 0, and read_o, write_o, meas_start_o, busy_o, done_o = 0.
REQ-024 Reset asserted mid-burst SHALL drop read_o/write_o immediately; no partial burst is resumed after release.
REQ-025 address_o, burstcount_o and writedata_o SHALL reset to 0.

Structure
REQ-026 The state enum (seq_state_t) and the mode encoding constants SHALL be added to rtl_settings_pkg.
REQ-027 Outstanding-read tracking (a FIFO of per-burst beat counts plus the counter) SHALL be a sub-module rd_outst_tracker; everything else stays flat.

Verification
REQ-028 Mode 0, base 0x100, 2 bursts x 4 beats, BYTE, DATA_B_W 4, no waitrequest -> 8 write beats; addresses 0x100, 0x110; done_o 9+ cycles after start.
REQ-029 Mode 1, 6 bursts x 2 beats, readdatavalid delayed 20 cycles -> outstanding peaks at 4; the 5th read_o waits until the first burst completes.
REQ-030 Mode 2 with waitrequest_i high for 3 cycles on every beat -> address/data stable while stalled; 4 writes then 4 reads, each from base.
REQ-031 meas_busy_i held high 10 cycles after the last read data -> done_o only after two low cycles of meas_busy_i.
REQ-032 Reset pulse in the middle of write beat 2 -> write_o low the same cycle; IDLE after release; a new start runs cleanly.
REQ-033 burst_num_i = 0 -> meas_start_o pulse, then done_o, with read_o/write_o never asserted.
